// File: rtl/mul_add_seq.sv
// Sequential unsigned multiply-accumulate P = A*B + C, one multiplier bit per clock.
// Start/busy/done handshake; P and ovf hold until the next completion.
module mul_add_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [WIDTH-1:0]     C,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   P,
    output logic                 ovf
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [2*WIDTH-1:0]   acc;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0]   sum;

    function automatic logic calc_ovf(input logic [2*WIDTH-1:0] v);
        return |v[2*WIDTH-1:WIDTH];
    endfunction

    // Partial product for the current multiplier bit; the 2*WIDTH sum never wraps.
    always_comb begin
        addend = '0;
        if (a_q[cnt])
            addend = {{WIDTH{1'b0}}, b_q} << cnt;
        sum = acc + addend;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            P     <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= A;
                        b_q   <= B;
                        acc   <= {{WIDTH{1'b0}}, C};
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= sum;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        P     <= sum;
                        ovf   <= calc_ovf(sum);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_add_seq.sv
// Randomised and directed bench for mul_add_seq against a plain-arithmetic A*B+C model.
module tb_mul_add_seq;

    localparam int W = 16;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic [W-1:0]     C;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   P;
    logic             ovf;

    int asserts  = 0;
    int failures = 0;

    mul_add_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .C     (C),
        .busy  (busy),
        .done  (done),
        .P     (P),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] model_p(input logic [W-1:0] a, b, c);
        longint r;
        r = longint'(a) * longint'(b) + longint'(c);
        return r[2*W-1:0];
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] a, b, c);
        longint r;
        r = longint'(a) * longint'(b) + longint'(c);
        return (r >> W) != 0;
    endfunction

    // Waits (bounded) for done; reports busy cycles seen and whether busy overlapped done.
    task automatic wait_done(output int busy_cycles, output logic timed_out, output logic overlap);
        busy_cycles = 0;
        timed_out   = 1'b1;
        overlap     = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (done) begin
                timed_out = 1'b0;
                overlap   = busy;
                break;
            end
            if (busy) busy_cycles++;
        end
    endtask

    task automatic launch(input logic [W-1:0] a, b, c);
        @(negedge clk);
        A = a; B = b; C = c; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_and_check(input string name, input logic [W-1:0] a, b, c);
        int bc; logic to, ov;
        logic [2*W-1:0] ep; logic eo;
        ep = model_p(a, b, c);
        eo = model_ovf(a, b, c);
        launch(a, b, c);
        wait_done(bc, to, ov);
        asserts++;
        if (to !== 1'b0) begin
            failures++; $display("FAIL %s timeout: done never seen", name);
        end
        asserts++;
        if (P !== ep) begin
            failures++; $display("FAIL %s P: got %h expected %h", name, P, ep);
        end
        asserts++;
        if (ovf !== eo) begin
            failures++; $display("FAIL %s ovf: got %b expected %b", name, ovf, eo);
        end
        asserts++;
        if (bc !== W) begin
            failures++; $display("FAIL %s busy cycles: got %0d expected %0d", name, bc, W);
        end
        asserts++;
        if (ov !== 1'b0) begin
            failures++; $display("FAIL %s busy with done: got %b expected 0", name, ov);
        end
        @(negedge clk);
        asserts++;
        if (done !== 1'b0) begin
            failures++; $display("FAIL %s done width: got %b expected 0", name, done);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; C = '0;
        repeat (3) @(negedge clk);
        asserts++;
        if ({busy, done, ovf} !== 3'b000) begin
            failures++; $display("FAIL reset flags: got %b expected 000", {busy, done, ovf});
        end
        asserts++;
        if (P !== '0) begin
            failures++; $display("FAIL reset P: got %h expected 0", P);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        run_and_check("basic", 16'h0003, 16'h0007, 16'h0002);
        asserts++;
        if (P !== 32'h0000_0017) begin
            failures++; $display("FAIL basic const: got %h expected 00000017", P);
        end
    endtask

    task automatic test_divider;
        run_and_check("divider", 16'h008E, 16'h0007, 16'h0006);
        asserts++;
        if (P !== 32'h0000_03E8) begin
            failures++; $display("FAIL divider const: got %h expected 000003e8", P);
        end
    endtask

    task automatic test_max_zero;
        run_and_check("max", 16'hFFFF, 16'hFFFF, 16'hFFFF);
        asserts++;
        if ({ovf, P} !== {1'b1, 32'hFFFF_0000}) begin
            failures++; $display("FAIL max const: got %b/%h expected 1/ffff0000", ovf, P);
        end
        run_and_check("zero_a", 16'h0000, 16'h1234, 16'h00AB);
        run_and_check("zero_b", 16'h5A5A, 16'h0000, 16'h0042);
    endtask

    task automatic test_random;
        for (int i = 0; i < 10; i++)
            run_and_check("random", W'($urandom), W'($urandom), W'($urandom));
    endtask

    task automatic test_start_during_busy;
        int bc; logic to, ov;
        logic [W-1:0] a1, b1, c1, a2, b2, c2;
        a1 = 16'h1357; b1 = 16'h2468; c1 = 16'h0ABC;
        a2 = 16'h00FF; b2 = 16'h0101; c2 = 16'h0033;
        launch(a1, b1, c1);
        repeat (5) @(negedge clk);
        A = a2; B = b2; C = c2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(bc, to, ov);
        asserts++;
        if (to !== 1'b0 || P !== model_p(a1, b1, c1)) begin
            failures++; $display("FAIL busy_start: got %h expected %h", P, model_p(a1, b1, c1));
        end
        @(negedge clk);
        // Start held through DONE: the first result completes, then the second is taken from IDLE.
        launch(a1, b1, c1);
        A = a2; B = b2; C = c2; start = 1'b1;
        wait_done(bc, to, ov);
        asserts++;
        if (to !== 1'b0 || P !== model_p(a1, b1, c1)) begin
            failures++; $display("FAIL held_first: got %h expected %h", P, model_p(a1, b1, c1));
        end
        @(posedge clk);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(bc, to, ov);
        asserts++;
        if (to !== 1'b0 || P !== model_p(a2, b2, c2)) begin
            failures++; $display("FAIL held_second: got %h expected %h", P, model_p(a2, b2, c2));
        end
        @(negedge clk);
    endtask

    task automatic test_input_stability;
        logic [W-1:0] a, b, c;
        logic got;
        a = W'($urandom); b = W'($urandom); c = W'($urandom);
        launch(a, b, c);
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (done) got = 1'b1;
            A = W'($urandom); B = W'($urandom); C = W'($urandom);
        end
        asserts++;
        if (!got || P !== model_p(a, b, c)) begin
            failures++; $display("FAIL stability: got %h expected %h", P, model_p(a, b, c));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic seen;
        launch(16'h7777, 16'h3333, 16'h0001);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        asserts++;
        if ({busy, done, ovf} !== 3'b000 || P !== '0) begin
            failures++; $display("FAIL reset_mid: got %b/%h expected 000/0", {busy, done, ovf}, P);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        asserts++;
        if (seen !== 1'b0) begin
            failures++; $display("FAIL reset_no_done: got activity %b expected 0", seen);
        end
        run_and_check("after_reset", 16'h0002, 16'h0003, 16'h0001);
        asserts++;
        if (P !== 32'h0000_0007) begin
            failures++; $display("FAIL after_reset const: got %h expected 00000007", P);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_divider();
        test_max_zero();
        test_random();
        test_start_during_busy();
        test_input_stability();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
